as2650_extbus: RTL and testbench



---
 rtl/as2650_extbus_pkg.sv | 28 ++
 rtl/as2650_extbus_if.sv | 31 +++
 rtl/as2650_extbus_sync2.sv | 33 +++
 rtl/as2650_extbus.sv | 214 +++++++++++++++++++++
 tb/tb_as2650_extbus.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/as2650_extbus_pkg.sv
// ---------------------------------------------------------------------------
// as2650_bus_pkg
// Shared types and constants for the AS2650 external-bus controller:
//   bus_state_e   bus-cycle sequencer states
//   SYNC_STAGES   depth of the pad_wait synchroniser
//   WAIT_CNT_W    width of the programmable wait-state counter (0..15)
//   to_cnt_width  timeout counter width for a given TIMEOUT value
// ---------------------------------------------------------------------------
package as2650_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STRB,
        ST_HOLD,
        ST_TURN
    } bus_state_e;

    localparam int SYNC_STAGES = 2;
    localparam int WAIT_CNT_W  = 4;

    // ceil(log2(timeout+1)) bits, never narrower than one bit so the
    // counter still exists when the timeout is disabled.
    function automatic int to_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/as2650_extbus_if.sv
// ---------------------------------------------------------------------------
// as2650_extbus_if
// Core-side request/response channel of the external-bus controller.
//   req/we/mio/addr/wdata  : core -> controller, req is a level held until ready
//   rdata/ready/err        : controller -> core, ready is a one-cycle pulse and
//                            err qualifies it (access aborted by timeout)
// Modports: master = core, slave = bus controller.
// ---------------------------------------------------------------------------
interface as2650_extbus_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic          mio;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          err;

    modport master (
        output req, we, mio, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, mio, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/as2650_extbus_sync2.sv
// ---------------------------------------------------------------------------
// as2650_sync2
// Multi-flop synchroniser (SYNC_STAGES deep) for the asynchronous pad_wait
// input. Resets to 0 so a held-in-reset bus never sees a phantom wait.
//   clk_i  clock            rst_i  async active-high reset
//   d_i    async input      q_o    synchronised output
// ---------------------------------------------------------------------------
module as2650_sync2
    import as2650_bus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: asynchronous reset belongs in the sensitivity list; a reset tested
    // only inside a posedge-clk block would be synchronous.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment lets every stage sample the old
            // value of its predecessor; blocking would collapse the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/as2650_extbus.sv
// ---------------------------------------------------------------------------
// as2650_extbus
// External-bus controller between the AS2650 core and the user I/O pads.
// Each access runs ADDR -> STRB (WAIT_STATES extra cycles) -> HOLD (extended
// by pad_wait, optionally aborted after TIMEOUT cycles) -> TURN (ready pulse,
// pads tristated) -> IDLE. Every pad output is a register, so the pad wrapper
// needs no logic of its own.
//   wb_clk_i, wb_rst_i     clock, async active-high reset
//   bus (slave)            core request/response channel
//   pad_adr, pad_mio       registered address / memory-vs-I/O
//   pad_dout, pad_oeb      data (or muxed low address) and per-bit active-low OE
//   pad_din                data from pads, latched at the end of HOLD on reads
//   pad_ale                address latch enable (MUX_AD=1 only)
//   pad_rd_n, pad_wr_n     active-low strobes
//   pad_wait               async external wait, active-high
// ---------------------------------------------------------------------------
module as2650_extbus
    import as2650_bus_pkg::*;
#(
    parameter int AW          = 13,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 0,
    parameter int MUX_AD      = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    as2650_extbus_if.slave bus,
    output logic [AW-1:0] pad_adr,
    output logic [DW-1:0] pad_dout,
    input  logic [DW-1:0] pad_din,
    output logic [DW-1:0] pad_oeb,
    output logic          pad_ale,
    output logic          pad_rd_n,
    output logic          pad_wr_n,
    output logic          pad_mio,
    input  logic          pad_wait
);

    localparam int TCW         = to_cnt_width(TIMEOUT);
    localparam int TO_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TCW-1:0]        TO_LAST = TO_LAST_INT[TCW-1:0];
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

    bus_state_e state_q, state_d;

    logic                  we_q,    we_d;
    logic                  mio_q,   mio_d;
    logic [AW-1:0]         adr_q,   adr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [WAIT_CNT_W-1:0] wcnt_q,  wcnt_d;
    logic [TCW-1:0]        tcnt_q,  tcnt_d;
    logic                  abort_q, abort_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    logic [DW-1:0]         dout_q,  dout_d;
    logic [DW-1:0]         oeb_q,   oeb_d;
    logic                  ale_q,   ale_d;
    logic                  rd_n_q,  rd_n_d;
    logic                  wr_n_q,  wr_n_d;

    logic                  wait_s;

    as2650_sync2 u_wait_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (pad_wait),
        .q_o   (wait_s)
    );

    // Sequencer next state plus datapath next values.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        we_d    = we_q;
        mio_d   = mio_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        abort_d = abort_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    mio_d   = bus.mio;
                    adr_d   = bus.addr;
                    wdata_d = bus.wdata;
                    abort_d = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                wcnt_d  = WS_LOAD;
                state_d = ST_STRB;
            end
            ST_STRB: begin
                if (wcnt_q == '0) begin
                    tcnt_d  = '0;
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (!wait_s) begin
                    if (!we_q) rdata_d = pad_din;
                    state_d = ST_TURN;
                end else if (TIMEOUT != 0 && tcnt_q == TO_LAST) begin
                    // This waiting cycle brings the count to TIMEOUT: abort.
                    abort_d = 1'b1;
                    if (!we_q) rdata_d = '1;
                    state_d = ST_TURN;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pad values are decoded from the state being entered so that they appear
    // registered in the same cycle as that state.
    always_comb begin
        dout_d = dout_q;
        oeb_d  = '1;
        ale_d  = 1'b0;
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;

        unique case (state_d)
            ST_ADDR: begin
                if (MUX_AD != 0) begin
                    ale_d  = 1'b1;
                    dout_d = adr_d[DW-1:0];
                    oeb_d  = '0;
                end else if (we_d) begin
                    dout_d = wdata_d;
                    oeb_d  = '0;
                end
            end
            ST_STRB, ST_HOLD: begin
                rd_n_d = we_d;
                wr_n_d = !we_d;
                if (we_d) begin
                    dout_d = wdata_d;
                    oeb_d  = '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Reset drives strobes high and pads tristated immediately, dropping any
    // access in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q    <= 1'b0;
            mio_q   <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            abort_q <= 1'b0;
            rdata_q <= '0;
            dout_q  <= '0;
            oeb_q   <= '1;
            ale_q   <= 1'b0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            we_q    <= we_d;
            mio_q   <= mio_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            oeb_q   <= oeb_d;
            ale_q   <= ale_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

    assign pad_adr   = adr_q;
    assign pad_mio   = mio_q;
    assign pad_dout  = dout_q;
    assign pad_oeb   = oeb_q;
    assign pad_ale   = ale_q;
    assign pad_rd_n  = rd_n_q;
    assign pad_wr_n  = wr_n_q;

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == ST_TURN);
    assign bus.err   = (state_q == ST_TURN) && abort_q;

endmodule

// File: tb/tb_as2650_extbus.sv
// ---------------------------------------------------------------------------
// tb_as2650_extbus
// Three controller instances: 0 = WAIT_STATES 0, TIMEOUT 255; 1 = WAIT_STATES 2;
// 2 = MUX_AD 1, TIMEOUT 8. Each access pushes its expected completion
// (instance, start cycle, latency, rdata, err) to a scoreboard queue; a
// monitor pops and compares on every ready pulse. Phase-by-phase pad values
// are checked inline while the access runs.
// ---------------------------------------------------------------------------
module tb_as2650_extbus;

    typedef struct {
        int         idx;
        int         start;
        int         lat;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       rst_v;
    logic [2:0]       req_v, we_v, mio_v;
    logic [2:0][12:0] addr_v;
    logic [2:0][7:0]  wdata_v;
    logic [7:0]       pad_din;
    logic             pad_wait;

    logic [2:0][7:0]  rdata_v, dout_v, oeb_v;
    logic [2:0][12:0] adr_v;
    logic [2:0]       rdy_v, err_v, ale_v, rd_n_v, wr_n_v, mio_o_v;

    as2650_extbus_if #(.AW(13), .DW(8)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req   = req_v[g];
        assign bus[g].we    = we_v[g];
        assign bus[g].mio   = mio_v[g];
        assign bus[g].addr  = addr_v[g];
        assign bus[g].wdata = wdata_v[g];
        assign rdata_v[g]   = bus[g].rdata;
        assign rdy_v[g]     = bus[g].ready;
        assign err_v[g]     = bus[g].err;

        as2650_extbus #(
            .AW          (13),
            .DW          (8),
            .WAIT_STATES ((g == 1) ? 2 : 0),
            .MUX_AD      ((g == 2) ? 1 : 0),
            .TIMEOUT     ((g == 2) ? 8 : 255)
        ) u_dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst_v[g]),
            .bus      (bus[g]),
            .pad_adr  (adr_v[g]),
            .pad_dout (dout_v[g]),
            .pad_din  (pad_din),
            .pad_oeb  (oeb_v[g]),
            .pad_ale  (ale_v[g]),
            .pad_rd_n (rd_n_v[g]),
            .pad_wr_n (wr_n_v[g]),
            .pad_mio  (mio_o_v[g]),
            .pad_wait (pad_wait)
        );
    end

    int n_vec = 0;
    int n_err = 0;
    exp_t sb_q[$];
    logic [7:0] last_rd [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_mux(input int idx);
        return idx == 2;
    endfunction

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdy_v[i]) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ready_instance", i, mon_e.idx);
                    check("rdata", rdata_v[i], mon_e.rdata);
                    check("err", err_v[i], mon_e.err);
                    check("latency", cyc - mon_e.start, mon_e.lat);
                end
            end else if (err_v[i]) begin
                check("err_without_ready", 32'd1, 32'd0);
            end
        end
    end

    task automatic access(input int idx, input bit w, input bit m,
                          input logic [12:0] a, input logic [7:0] wd,
                          input logic [7:0] din, input int wait_len,
                          input int lat, input bit exp_err);
        exp_t e;
        int   n;
        bit   done;
        int   strb;
        @(negedge clk);
        n       = cyc;
        e.idx   = idx;
        e.start = n;
        e.lat   = lat;
        e.err   = exp_err;
        e.rdata = w ? last_rd[idx] : (exp_err ? 8'hFF : din);
        last_rd[idx] = e.rdata;
        sb_q.push_back(e);
        req_v[idx]   = 1'b1;
        we_v[idx]    = w;
        mio_v[idx]   = m;
        addr_v[idx]  = a;
        wdata_v[idx] = wd;
        pad_din      = din;
        pad_wait     = (wait_len > 0);
        done = 1'b0;
        strb = 0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (wait_len > 0 && k == wait_len + 1) pad_wait = 1'b0;
            if ((w ? wr_n_v[idx] : rd_n_v[idx]) == 1'b0) strb++;
            check("other_strobe_high", w ? rd_n_v[idx] : wr_n_v[idx], 1);
            if (k == 1) begin
                check("addr_adr", adr_v[idx], a);
                check("addr_mio", mio_o_v[idx], m);
                check("addr_ale", ale_v[idx], is_mux(idx));
                check("addr_oeb", oeb_v[idx], (is_mux(idx) || w) ? 8'h00 : 8'hFF);
                if (is_mux(idx)) check("addr_dout", dout_v[idx], a[7:0]);
                // Captured values must not follow the core after ADDR.
                addr_v[idx]  = ~a;
                wdata_v[idx] = ~wd;
                mio_v[idx]   = ~m;
            end else if (rdy_v[idx]) begin
                check("turn_oeb", oeb_v[idx], 8'hFF);
                check("turn_rd_n", rd_n_v[idx], 1);
                check("turn_wr_n", wr_n_v[idx], 1);
                check("strobe_cycles", strb, lat - 2);
                req_v[idx] = 1'b0;
                done = 1'b1;
            end else begin
                check("strb_oeb", oeb_v[idx], w ? 8'h00 : 8'hFF);
                check("strb_ale", ale_v[idx], 0);
                check("strb_adr_held", adr_v[idx], a);
                if (w) check("strb_dout", dout_v[idx], wd);
            end
        end
        if (!done) begin
            check("ready_timeout", 32'd0, 32'd1);
            req_v[idx] = 1'b0;
        end
        pad_wait = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    bit b2b_first;
    bit b2b_done;
    int b2b_n;
    exp_t b2b_e;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_v    = '1;
        req_v    = '0;
        we_v     = '0;
        mio_v    = '0;
        addr_v   = '0;
        wdata_v  = '0;
        pad_din  = '0;
        pad_wait = 1'b0;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_rd_n", rd_n_v[i], 1);
            check("rst_wr_n", wr_n_v[i], 1);
            check("rst_ale", ale_v[i], 0);
            check("rst_oeb", oeb_v[i], 8'hFF);
            check("rst_ready", rdy_v[i], 0);
            check("rst_err", err_v[i], 0);
            check("rst_adr", adr_v[i], 0);
            check("rst_dout", dout_v[i], 0);
            check("rst_rdata", rdata_v[i], 0);
            check("rst_mio", mio_o_v[i], 0);
        end
        rst_v = '0;
        @(negedge clk);

        // idx, we, mio, addr, wdata, din, wait_len, latency, err
        access(0, 0, 1, 13'h1A5, 8'h00, 8'h3C, 0,    4,  0);
        access(0, 0, 1, 13'h0C3, 8'h00, 8'h5A, 10,   14, 0);
        access(0, 1, 0, 13'h012, 8'h77, 8'h00, 0,    4,  0);
        access(1, 1, 1, 13'h1FF, 8'hA5, 8'h00, 0,    6,  0);
        access(1, 0, 1, 13'h020, 8'h00, 8'h96, 0,    6,  0);
        access(2, 0, 1, 13'h0F7, 8'h00, 8'hC3, 0,    4,  0);
        access(2, 0, 0, 13'h0F0, 8'h00, 8'h3C, 1000, 11, 1);
        access(2, 1, 1, 13'h003, 8'h5E, 8'h00, 0,    4,  0);

        // Reset in the middle of a read strobe on instance 0.
        @(negedge clk);
        req_v[0]  = 1'b1;
        we_v[0]   = 1'b0;
        mio_v[0]  = 1'b1;
        addr_v[0] = 13'h055;
        pad_din   = 8'h00;
        repeat (2) @(negedge clk);
        check("pre_rst_rd_n", rd_n_v[0], 0);
        rst_v[0] = 1'b1;
        #1;
        check("midrst_rd_n", rd_n_v[0], 1);
        check("midrst_oeb", oeb_v[0], 8'hFF);
        check("midrst_ready", rdy_v[0], 0);
        req_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_v[0] = 1'b0;
        last_rd[0] = 8'h00;
        repeat (2) @(negedge clk);
        access(0, 0, 1, 13'h0AA, 8'h00, 8'h69, 0, 4, 0);

        // Back-to-back reads with req held across TURN.
        @(negedge clk);
        b2b_n = cyc;
        b2b_e.idx = 0; b2b_e.start = b2b_n;     b2b_e.lat = 4; b2b_e.rdata = 8'h11; b2b_e.err = 1'b0;
        sb_q.push_back(b2b_e);
        b2b_e.idx = 0; b2b_e.start = b2b_n + 5; b2b_e.lat = 4; b2b_e.rdata = 8'h22; b2b_e.err = 1'b0;
        sb_q.push_back(b2b_e);
        last_rd[0] = 8'h22;
        req_v[0]  = 1'b1;
        we_v[0]   = 1'b0;
        mio_v[0]  = 1'b1;
        addr_v[0] = 13'h100;
        pad_din   = 8'h11;
        b2b_first = 1'b0;
        b2b_done  = 1'b0;
        for (int k = 1; k <= 40 && !b2b_done; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check("b2b_idle_adr", adr_v[0], 13'h100);
                check("b2b_idle_rd_n", rd_n_v[0], 1);
            end
            if (k == 6) check("b2b_addr_adr", adr_v[0], 13'h0AB);
            if (rdy_v[0] && !b2b_first) begin
                b2b_first = 1'b1;
                addr_v[0] = 13'h0AB;
                pad_din   = 8'h22;
            end else if (rdy_v[0]) begin
                req_v[0] = 1'b0;
                b2b_done = 1'b1;
            end
        end
        if (!b2b_done) begin
            check("b2b_ready_timeout", 32'd0, 32'd1);
            req_v[0] = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
